// File: rtl/hamm_tx_ctrl.sv
// hamm_tx_ctrl
// Sequencing controller for the (7,4) Hamming encoder stage.
// Packs a serial bit stream into nibbles. Each nibble goes to the encoder
// with a one-cycle load strobe. The controller then captures the encoder's
// registered codeword and shifts it out serially. Every output is registered.
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   clr             synchronous abort: drop the partial nibble or pending codeword
//   bit_in/bit_valid/bit_ready   serial input handshake
//   enc_data        nibble presented to the encoder
//   enc_strobe      encoder load strobe; SUCCESS_LEVEL means "nibble valid"
//   enc_code        registered codeword returned by the encoder
//   tx_bit/tx_valid/tx_ready     serial codeword output handshake
//   tx_sof          high with the first bit of each codeword
//   busy            high in any state other than IDLE
//   frame_cnt       codewords fully transmitted, modulo 256
module hamm_tx_ctrl #(
    parameter logic MSB_FIRST     = 1'b1,
    parameter logic SUCCESS_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [3:0] enc_data,
    output logic       enc_strobe,
    input  logic [6:0] enc_code,
    output logic       tx_bit,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_sof,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_STROBE,
        S_CAPTURE,
        S_SHIFT
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] nib_q, nib_d, nib_next;
    logic [3:0] enc_data_q, enc_data_d;
    logic [6:0] sreg_q, sreg_d, sreg_next;
    logic       bit_ready_q, bit_ready_d;
    logic       enc_strobe_q, enc_strobe_d;
    logic       tx_bit_q, tx_bit_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_sof_q, tx_sof_d;
    logic       busy_q, busy_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        // After four shifts the first bit lands in bit 3 (MSB_FIRST) or bit 0.
        nib_next  = MSB_FIRST ? {nib_q[2:0], bit_in} : {bit_in, nib_q[3:1]};
        sreg_next = MSB_FIRST ? {sreg_q[5:0], 1'b0} : {1'b0, sreg_q[6:1]};

        state_d      = state_q;
        cnt_d        = cnt_q;
        nib_d        = nib_q;
        enc_data_d   = enc_data_q;
        sreg_d       = sreg_q;
        bit_ready_d  = bit_ready_q;
        enc_strobe_d = enc_strobe_q;
        tx_bit_d     = tx_bit_q;
        tx_valid_d   = tx_valid_q;
        tx_sof_d     = tx_sof_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (bit_valid && bit_ready_q) begin
                    nib_d = nib_next;
                    if (cnt_q == 3'd3) begin
                        state_d      = S_STROBE;
                        cnt_d        = '0;
                        enc_data_d   = nib_next;
                        enc_strobe_d = SUCCESS_LEVEL;
                        bit_ready_d  = 1'b0;
                    end else begin
                        state_d = S_COLLECT;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            S_STROBE: begin
                state_d      = S_CAPTURE;
                enc_strobe_d = ~SUCCESS_LEVEL;
            end
            S_CAPTURE: begin
                // The encoder latched on the strobe edge, so its codeword is valid now.
                state_d    = S_SHIFT;
                sreg_d     = enc_code;
                tx_bit_d   = MSB_FIRST ? enc_code[6] : enc_code[0];
                tx_valid_d = 1'b1;
                tx_sof_d   = 1'b1;
                cnt_d      = '0;
            end
            S_SHIFT: begin
                if (tx_ready) begin
                    tx_sof_d = 1'b0;
                    if (cnt_q == 3'd6) begin
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        nib_d       = '0;
                        tx_valid_d  = 1'b0;
                        bit_ready_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        cnt_d    = cnt_q + 3'd1;
                        sreg_d   = sreg_next;
                        tx_bit_d = MSB_FIRST ? sreg_q[5] : sreg_q[1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any handshake on the same edge.
        if (clr) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            nib_d        = '0;
            enc_data_d   = enc_data_q;
            sreg_d       = sreg_q;
            bit_ready_d  = 1'b1;
            enc_strobe_d = ~SUCCESS_LEVEL;
            tx_bit_d     = tx_bit_q;
            tx_valid_d   = 1'b0;
            tx_sof_d     = 1'b0;
            frame_cnt_d  = frame_cnt_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            nib_q        <= '0;
            enc_data_q   <= '0;
            sreg_q       <= '0;
            bit_ready_q  <= 1'b1;
            enc_strobe_q <= ~SUCCESS_LEVEL;
            tx_bit_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_sof_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nib_q        <= nib_d;
            enc_data_q   <= enc_data_d;
            sreg_q       <= sreg_d;
            bit_ready_q  <= bit_ready_d;
            enc_strobe_q <= enc_strobe_d;
            tx_bit_q     <= tx_bit_d;
            tx_valid_q   <= tx_valid_d;
            tx_sof_q     <= tx_sof_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign enc_data   = enc_data_q;
    assign enc_strobe = enc_strobe_q;
    assign tx_bit     = tx_bit_q;
    assign tx_valid   = tx_valid_q;
    assign tx_sof     = tx_sof_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
